// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared definitions for the multiplexed 7-segment display
//                driver: symbol codes, active-high segment patterns (abcdefg,
//                bit 0 = segment a) and the stored digit record.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Number of segments driven per digit (a..g, no decimal point)
    localparam int SEG_W = 7;

    // Symbol codes above the hex range (0x00-0x0F are hex digits)
    localparam logic [4:0] SIM_BLANK = 5'h10;
    localparam logic [4:0] SIM_TRACO = 5'h11;  // '-'
    localparam logic [4:0] SIM_H     = 5'h12;
    localparam logic [4:0] SIM_L     = 5'h13;
    localparam logic [4:0] SIM_P     = 5'h14;
    localparam logic [4:0] SIM_U     = 5'h15;
    localparam logic [4:0] SIM_R     = 5'h16;  // 'r'
    localparam logic [4:0] SIM_N     = 5'h17;  // 'n'
    localparam logic [4:0] SIM_O     = 5'h18;  // 'o'
    localparam logic [4:0] SIM_Y     = 5'h19;  // 'y'
    localparam logic [4:0] SIM_J     = 5'h1A;
    localparam logic [4:0] SIM_SUB   = 5'h1B;  // '_'

    // Active-high segment patterns, written abcdefg left to right
    localparam logic [0:SEG_W-1] SEG_0     = 7'b1111110;
    localparam logic [0:SEG_W-1] SEG_1     = 7'b0110000;
    localparam logic [0:SEG_W-1] SEG_2     = 7'b1101101;
    localparam logic [0:SEG_W-1] SEG_3     = 7'b1111001;
    localparam logic [0:SEG_W-1] SEG_4     = 7'b0110011;
    localparam logic [0:SEG_W-1] SEG_5     = 7'b1011011;
    localparam logic [0:SEG_W-1] SEG_6     = 7'b1011111;
    localparam logic [0:SEG_W-1] SEG_7     = 7'b1110000;
    localparam logic [0:SEG_W-1] SEG_8     = 7'b1111111;
    localparam logic [0:SEG_W-1] SEG_9     = 7'b1111011;
    localparam logic [0:SEG_W-1] SEG_A     = 7'b1110111;
    localparam logic [0:SEG_W-1] SEG_B     = 7'b0011111;
    localparam logic [0:SEG_W-1] SEG_C     = 7'b1001110;
    localparam logic [0:SEG_W-1] SEG_D     = 7'b0111101;
    localparam logic [0:SEG_W-1] SEG_E     = 7'b1001111;
    localparam logic [0:SEG_W-1] SEG_F     = 7'b1000111;
    localparam logic [0:SEG_W-1] SEG_TRACO = 7'b0000001;
    localparam logic [0:SEG_W-1] SEG_H     = 7'b0110111;
    localparam logic [0:SEG_W-1] SEG_L     = 7'b0001110;
    localparam logic [0:SEG_W-1] SEG_P     = 7'b1100111;
    localparam logic [0:SEG_W-1] SEG_U     = 7'b0111110;
    localparam logic [0:SEG_W-1] SEG_R     = 7'b0000101;
    localparam logic [0:SEG_W-1] SEG_N     = 7'b0010101;
    localparam logic [0:SEG_W-1] SEG_O     = 7'b0011101;
    localparam logic [0:SEG_W-1] SEG_Y     = 7'b0111011;
    localparam logic [0:SEG_W-1] SEG_J     = 7'b0111000;
    localparam logic [0:SEG_W-1] SEG_SUB   = 7'b0001000;
    localparam logic [0:SEG_W-1] SEG_BLANK = 7'b0000000;

    // One stored digit: blink flag plus symbol code
    typedef struct packed {
        logic       blink;
        logic [4:0] code;
    } digito_t;

    // Content of every digit slot after reset
    localparam digito_t DIG_RESET = '{blink: 1'b0, code: SIM_BLANK};

endpackage
`default_nettype wire

// File: rtl/decod_simbolo_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : decod_simbolo_7seg
//  Description : Pure combinational 5-bit symbol code to 7-segment map.
//                Output is active-high, bit 0 = segment a, bit 6 = segment g.
//                Codes outside the defined set produce a blank digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module decod_simbolo_7seg
    import disp_pkg::*;
(
    input  logic [4:0]       i_simbolo,
    output logic [0:SEG_W-1] o_segs
);

    // Symbol lookup; anything unlisted renders as blank
    always_comb begin
        o_segs = SEG_BLANK;
        case (i_simbolo)
            5'h00:     o_segs = SEG_0;
            5'h01:     o_segs = SEG_1;
            5'h02:     o_segs = SEG_2;
            5'h03:     o_segs = SEG_3;
            5'h04:     o_segs = SEG_4;
            5'h05:     o_segs = SEG_5;
            5'h06:     o_segs = SEG_6;
            5'h07:     o_segs = SEG_7;
            5'h08:     o_segs = SEG_8;
            5'h09:     o_segs = SEG_9;
            5'h0A:     o_segs = SEG_A;
            5'h0B:     o_segs = SEG_B;
            5'h0C:     o_segs = SEG_C;
            5'h0D:     o_segs = SEG_D;
            5'h0E:     o_segs = SEG_E;
            5'h0F:     o_segs = SEG_F;
            SIM_BLANK: o_segs = SEG_BLANK;
            SIM_TRACO: o_segs = SEG_TRACO;
            SIM_H:     o_segs = SEG_H;
            SIM_L:     o_segs = SEG_L;
            SIM_P:     o_segs = SEG_P;
            SIM_U:     o_segs = SEG_U;
            SIM_R:     o_segs = SEG_R;
            SIM_N:     o_segs = SEG_N;
            SIM_O:     o_segs = SEG_O;
            SIM_Y:     o_segs = SEG_Y;
            SIM_J:     o_segs = SEG_J;
            SIM_SUB:   o_segs = SEG_SUB;
            default:   o_segs = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_mux_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux_7seg
//  Description : N-digit time-multiplexed 7-segment driver with a
//                double-buffered digit bank. Control logic writes the shadow
//                bank; a commit request copies it to the display bank at the
//                next full-frame boundary so a frame never shows a mix of old
//                and new content. Digits flagged for blinking are blanked
//                during the odd blink phase while their enable stays on.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux_7seg
    import disp_pkg::*;
#(
    parameter int N_DIG           = 4,
    parameter int PRESC           = 1000,
    parameter int BLINK_FRAMES    = 64,
    parameter int SEG_ATIVO_BAIXO = 0,
    parameter int AN_ATIVO_BAIXO  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(N_DIG)-1:0] wr_addr,
    input  logic [4:0]               wr_data,
    input  logic                     wr_blink,
    input  logic                     atualiza,
    output logic                     pendente,
    output logic [0:SEG_W-1]         saida,
    output logic [N_DIG-1:0]         an
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_IDX_W   = $clog2(N_DIG);
    localparam int c_PRESC_W = $clog2(PRESC);
    // A single-frame blink period still needs a 1-bit counter to exist
    localparam int c_FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_IDX_W-1:0]   c_IDX_MAX   = c_IDX_W'(N_DIG - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(PRESC - 1);
    localparam logic [c_FRM_W-1:0]   c_FRM_MAX   = c_FRM_W'(BLINK_FRAMES - 1);

    // "Off" level of each output bus; XOR with it converts active-high
    // internal values to the board polarity
    localparam logic [0:SEG_W-1] c_SEG_OFF =
        (SEG_ATIVO_BAIXO != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [N_DIG-1:0] c_AN_OFF =
        (AN_ATIVO_BAIXO != 0) ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
    localparam logic [N_DIG-1:0] c_AN_ONE = N_DIG'(1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_FRM_W-1:0]   r_frm;
    logic                 r_phase;
    logic                 r_pend;
    logic [0:SEG_W-1]     r_saida;
    logic [N_DIG-1:0]     r_an;

    logic                 w_tick;
    logic                 w_last;
    logic                 w_frame;
    logic                 w_commit;
    digito_t              w_wr_dig;
    digito_t              w_disp [N_DIG];
    digito_t              w_cur;
    logic [4:0]           w_sym;
    logic [0:SEG_W-1]     w_segs;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    assign w_tick   = (r_presc == c_PRESC_MAX);
    assign w_last   = (r_idx == c_IDX_MAX);
    assign w_frame  = w_tick & w_last;
    // A request raised in the boundary cycle itself is honoured right away
    assign w_commit = w_frame & (r_pend | atualiza);

    // Slot prescaler: counts clocks within one digit slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit index: advances once per slot, wraps after the leftmost digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (w_last) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Frame counter and blink phase: phase flips every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
        end else if (w_frame) begin
            if (r_frm == c_FRM_MAX) begin
                r_frm   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frm <= r_frm + 1'b1;
            end
        end
    end

    // Commit request flag: held until the next frame boundary consumes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (w_frame) begin
            r_pend <= 1'b0;
        end else if (atualiza) begin
            r_pend <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double-buffered digit bank, one shadow/display pair per digit.
    // Address decoding per digit means out-of-range addresses match no
    // slot and are dropped without side effects.
    // ------------------------------------------------------------------
    assign w_wr_dig = '{blink: wr_blink, code: wr_data};

    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        localparam logic [c_IDX_W-1:0] c_MY_ADDR = c_IDX_W'(gi);

        digito_t r_shadow;
        digito_t r_disp;

        // Shadow slot: written by the control-side port
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= DIG_RESET;
            end else if (wr_en && (wr_addr == c_MY_ADDR)) begin
                r_shadow <= w_wr_dig;
            end
        end

        // Display slot: takes the pre-edge shadow value on commit, so a
        // write in the same cycle lands only in the shadow bank
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_disp <= DIG_RESET;
            end else if (w_commit) begin
                r_disp <= r_shadow;
            end
        end

        assign w_disp[gi] = r_disp;
    end

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    assign w_cur = w_disp[r_idx];
    // Blinking digits are blanked by substituting the blank symbol
    assign w_sym = (r_phase && w_cur.blink) ? SIM_BLANK : w_cur.code;

    decod_simbolo_7seg u_decod (
        .i_simbolo (w_sym),
        .o_segs    (w_segs)
    );

    // Registered pins: one clock behind the index/content that drive them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_saida <= c_SEG_OFF;
            r_an    <= c_AN_OFF;
        end else begin
            r_saida <= w_segs ^ c_SEG_OFF;
            r_an    <= (c_AN_ONE << r_idx) ^ c_AN_OFF;
        end
    end

    assign pendente = r_pend;
    assign saida    = r_saida;
    assign an       = r_an;

endmodule
`default_nettype wire
